// File: rtl/serial_adder_8bit_if.sv
// Request/result bundle for the bit-serial adder: the master issues start with
// operands, the slave returns busy/done and the registered result.
interface serial_adder_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] SA_in1;
    logic [WIDTH-1:0] SA_in2;
    logic             SA_cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SA_sum;
    logic             SA_cout;
    logic             SA_ovf;

    modport master (
        output start, SA_in1, SA_in2, SA_cin,
        input  busy, done, SA_sum, SA_cout, SA_ovf
    );

    modport slave (
        input  start, SA_in1, SA_in2, SA_cin,
        output busy, done, SA_sum, SA_cout, SA_ovf
    );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial ripple adder: one bit per cycle LSB first, WIDTH+2 cycles per
// operation including the DONE beat and the IDLE turnaround.
module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_adder_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
    logic             carry;
    logic             p, g, s, c_nx, last;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic             busy, done;

    // One full-adder slice built from the propagate/generate half-adder pair.
    always_comb begin
        p      = a_sr[0] ^ b_sr[0];
        g      = a_sr[0] & b_sr[0];
        s      = p ^ carry;
        c_nx   = g | (p & carry);
        res_nx = {s, res_sr[WIDTH-1:1]};
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = ADD;
            ADD: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sr   <= bus.SA_in1;
                    b_sr   <= bus.SA_in2;
                    carry  <= bus.SA_cin;
                    res_sr <= '0;
                    cnt    <= '0;
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nx;
                    carry  <= c_nx;
                    cnt    <= cnt + CW'(1);
                    // Publish on the last bit so results appear as DONE is entered;
                    // carry still holds the carry into the MSB here.
                    if (last) begin
                        sum_q  <= res_nx;
                        cout_q <= c_nx;
                        ovf_q  <= carry ^ c_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.SA_sum  = sum_q;
    assign bus.SA_cout = cout_q;
    assign bus.SA_ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_8bit.sv
// Bench for serial_adder_8bit: cycle-level reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_serial_adder_8bit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_8bit_if #(.WIDTH(W)) bus();
    serial_adder_8bit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from plain arithmetic: {cout, sum, signed overflow}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {t[W], t[W-1:0], ov};
    endfunction

    // Model: m_k counts cycles since an accepted start (0 = idle); the result
    // becomes visible WIDTH cycles after acceptance and lasts one DONE cycle.
    int             m_k = 0;
    logic [W+1:0]   m_pend = '0;
    logic [W-1:0]   m_sum = '0;
    logic           m_cout = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_k    <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_k == 0) begin
            if (bus.start) begin
                m_k    <= 1;
                m_pend <= ref_add(bus.SA_in1, bus.SA_in2, bus.SA_cin);
            end
        end else if (m_k == W) begin
            m_k <= W + 1;
            {m_cout, m_sum, m_ovf} <= m_pend;
        end else if (m_k == W + 1) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, m_k != 0);
            check("done", bus.done, m_k == W + 1);
            check("sum", bus.SA_sum, m_sum);
            check("cout", bus.SA_cout, m_cout);
            check("ovf", bus.SA_ovf, m_ovf);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input bit disturb, input bit chk_hold, input logic [W-1:0] hold_val,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int cyc   = 0;
        int nbusy = 0;
        bit seen  = 1'b0;
        bus.start  = 1'b1;
        bus.SA_in1 = a;
        bus.SA_in2 = b;
        bus.SA_cin = ci;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (disturb) begin
                bus.SA_in1 = 8'h11;
                bus.SA_in2 = 8'h11;
                bus.start  = (cyc == 2 || cyc == 5);
            end
            if (bus.busy) nbusy++;
            if (chk_hold && !bus.done) check("hold_sum", bus.SA_sum, hold_val);
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", cyc, W + 1);
        check("lit_sum", bus.SA_sum, e_sum);
        check("lit_cout", bus.SA_cout, e_cout);
        check("lit_ovf", bus.SA_ovf, e_ovf);
        @(negedge clk);
        check("busy_after", bus.busy, 0);
        check("busy_cycles", nbusy, W + 1);
    endtask

    initial begin
        int ndone;
        int last;
        int cyc;
        bus.start  = 1'b0;
        bus.SA_in1 = '0;
        bus.SA_in2 = '0;
        bus.SA_cin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.SA_sum, 0);
        check("rst_cout", bus.SA_cout, 0);
        check("rst_ovf", bus.SA_ovf, 0);

        // Start is raised in the same cycle reset drops.
        rst = 1'b0;
        run_op(8'h00, 8'h00, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0, 8'h00, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 0, 1, 8'h80, 8'h00, 1'b1, 1'b1);
        run_op(8'hA5, 8'h5A, 1'b1, 1, 0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Start pulses during ADD must not have queued another operation.
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no_extra_done", ndone, 0);

        run_op(8'h7F, 8'h01, 1'b0, 0, 0, 8'h00, 8'h80, 1'b0, 1'b1);

        // Abort mid-ADD with reset.
        bus.start  = 1'b1;
        bus.SA_in1 = 8'h3C;
        bus.SA_in2 = 8'h0F;
        bus.SA_cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("abort_no_done", bus.done, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum", bus.SA_sum, 8'h00);
        check("abort_ovf", bus.SA_ovf, 0);
        rst = 1'b0;
        run_op(8'h3C, 8'h0F, 1'b0, 0, 0, 8'h00, 8'h4B, 1'b0, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 0, 1, 8'h4B, 8'h02, 1'b0, 1'b0);

        // Back-to-back random traffic with start held high.
        ndone = 0;
        last  = -1;
        cyc   = 0;
        bus.start = 1'b1;
        while (ndone < 1000 && cyc < 11000) begin
            bus.SA_in1 = 8'($urandom);
            bus.SA_in2 = 8'($urandom);
            bus.SA_cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (last >= 0) check("done_period", cyc - last, W + 2);
                last = cyc;
                ndone++;
            end
        end
        bus.start = 1'b0;
        check("rand_count", ndone, 1000);
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: SA_in1  input  WIDTH  operand A, captured on an accepted start.
REQ-006 Port: SA_in2  input  WIDTH  operand B, captured on an accepted start.
REQ-007 Port: SA_cin  input  1  carry-in, captured on an accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (ADD or DONE state).
REQ-009 Port: done  output  1  single-cycle pulse: result is valid.
REQ-010 Port: SA_sum  output  WIDTH  registered sum, LSB first assembled.
REQ-011 Port: SA_cout  output  1  registered unsigned carry-out.
REQ-012 Port: SA_ovf  output  1  registered two's-complement overflow.

Function
REQ-013 The FSM SHALL have states IDLE, ADD and DONE, with a bit counter of width clog2(WIDTH)+1.
REQ-014 IDLE with start=1 SHALL capture SA_in1, SA_in2 and SA_cin into internal shift registers, clear the counter, and go to ADD; IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each ADD cycle SHALL process one bit, LSB first, as two half-adder steps:
  - p = a^b, g = a&b
  - s = p^c, c_next = g | (p&c)
  - s SHALL be shifted into the MSB of the internal result register, and the operand registers SHALL shift right.
REQ-016 ADD SHALL last exactly WIDTH cycles; on the WIDTH-th ADD edge the FSM SHALL go to DONE.
REQ-017 On entry to DONE:
  - SA_sum SHALL be loaded from the internal result register.
  - SA_cout SHALL be loaded from the final carry.
  - SA_ovf SHALL be loaded as carry-into-MSB XOR carry-out-of-MSB.
REQ-018 done SHALL be 1 only while in DONE (exactly one cycle); DONE SHALL always return to IDLE on the next edge.
REQ-019 Latency: start accepted at edge 0 -> done high in the cycle following edge WIDTH, i.e. WIDTH+1 cycles from start to done.
REQ-020 busy SHALL be 0 in IDLE and 1 in ADD and DONE.
REQ-021 start SHALL be ignored in ADD and DONE; captured operands SHALL be unaffected by input changes after capture.
REQ-022 SA_sum, SA_cout and SA_ovf SHALL hold the previous result through a subsequent operation until the next DONE entry.
REQ-023 Back-to-back: start high in the IDLE cycle right after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH: {SA_cout,SA_sum} = SA_in1 + SA_in2 + SA_cin, with no truncation of the carry.

Reset
REQ-025 rst=1 SHALL force IDLE and clear all of the following to 0:
  - counter, internal registers and carry
  - SA_sum, SA_cout, SA_ovf
  - busy and done
REQ-026 rst SHALL take priority over start and over any state; rst asserted mid-ADD SHALL abort with no done pulse and no output update.
REQ-027 After rst deasserts, the first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 0x00+0x00, cin=0 -> done at cycle 9 after start; SA_sum=0x00, cout=0, ovf=0; busy high for exactly 9 cycles.
REQ-029 0xFF+0x01, cin=0 -> SA_sum=0x00, cout=1, ovf=0.
REQ-030 0x7F+0x01, cin=0 -> SA_sum=0x80, cout=0, ovf=1; 0x80+0x80 -> SA_sum=0x00, cout=1, ovf=1.
REQ-031 0xA5+0x5A, cin=1 -> SA_sum=0x00, cout=1; operand inputs changed to 0x11 during ADD SHALL not alter the result; start pulsed during ADD SHALL produce no extra done.
REQ-032 Reset and hold checks:
  - Start 0x3C+0x0F, assert rst at ADD cycle 4 -> busy=0, done never pulses, SA_sum=0x00.
  - Then 0x3C+0x0F -> SA_sum=0x4B.
  - Previous SA_sum SHALL be held throughout the following ADD.
REQ-033 Random 1000 back-to-back operations, start asserted in every IDLE cycle -> each result matches the reference model, and done occurs every 10 cycles.
